reg_wr_arbiter: RTL

- Round-robin write arbiter that shares one loadable, resettable register between N_REQ requesters.
- Each requester offers a write through a valid/ready handshake. The arbiter grants one winner per accept, then drives a registered load_en/data pair into the downstream register's load port.
- After each write, an optional guard window of HOLD_CYC cycles blocks all further writes, giving consumers of the register time to settle.
- Sits between several control masters (CSR bus, debug, boot sequencer) and a shared configuration register.

---
 rtl/reg_wr_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter feeding one shared register load port.
// A guard window of HOLD_CYC cycles follows every accepted write.
module reg_wr_arbiter #(
   parameter int WIDTH    = 32,
   parameter int N_REQ    = 4,
   parameter int HOLD_CYC = 2,
   parameter int CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       reg_load_en,
   output logic [WIDTH-1:0]           reg_data,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic [CNT_W-1:0]           wr_cnt
);

   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic {
      IDLE,
      HOLD
   } state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             load_en_q, load_en_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       hold_q, hold_d;

   logic             win_found;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W:0]    cand;

   // Rotating priority search starting at rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      if (state_q == IDLE) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
               cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
               win_found = 1'b1;
               win_idx   = cand[ID_W-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      load_en_d = 1'b0;
      data_d    = data_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               load_en_d = 1'b1;
               data_d    = req_data[win_idx*WIDTH +: WIDTH];
               grant_d   = win_idx;
               cnt_d     = cnt_q + 1'b1;
               if (win_idx == ID_W'(N_REQ-1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = win_idx + 1'b1;
               end
               if (HOLD_CYC > 0) begin
                  state_d = HOLD;
                  hold_d  = 8'(HOLD_CYC);
               end
            end
         end
         HOLD: begin
            if (hold_q <= 8'd1) begin
               state_d = IDLE;
               hold_d  = '0;
            end else begin
               hold_d  = hold_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         load_en_q <= 1'b0;
         data_q    <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         load_en_q <= load_en_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
      end
   end

   assign reg_load_en = load_en_q;
   assign reg_data    = data_q;
   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign wr_cnt      = cnt_q;

endmodule
